// File: rtl/epp_pkg.sv
// Shared types and constants for the EPP slave front end.
package epp_pkg;

  // Shallowest synchronizer that still gives a metastability settling stage.
  localparam int unsigned EPP_SYNC_MIN = 2;

  // Cycle type, taken from the synchronized write strobe (low = write).
  localparam logic CYC_WRITE = 1'b0;
  localparam logic CYC_READ  = 1'b1;

  typedef enum logic [2:0] {
    StSettle,
    StIdle,
    StAwr,
    StArd,
    StDwr,
    StDrdReq,
    StDrdWait,
    StAck
  } epp_state_e;

  // True in every state where the slave owns the shared data bus.
  function automatic logic drives_bus(input epp_state_e st, input logic cyc_type);
    return (st == StArd) || (st == StDrdReq) || (st == StDrdWait) ||
           ((st == StAck) && (cyc_type == CYC_READ));
  endfunction

endpackage

// File: rtl/sync_vec.sv
// Multi-flop synchronizer for a vector of asynchronous inputs.
module sync_vec #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift chain; resets to zero so strobes read as "active" until real levels arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/epp_slave.sv
// EPP slave front end: synchronizes host strobes, runs the wait handshake,
// owns the address register and hands data cycles to the NAND sequencer.
module epp_slave
  import epp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_ndf,
  input  logic       rst,
  input  logic       epp_astb_n,
  input  logic       epp_dstb_n,
  input  logic       epp_wr_n,
  input  logic [7:0] epp_d_in,
  output logic [7:0] epp_q,
  output logic       epp_q_oe,
  output logic       epp_wait_n,
  output logic [7:0] cur_addr,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_addr,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  output logic [7:0] err_cnt
);

  // Too-shallow settings are clamped rather than silently losing the settling stage.
  localparam int unsigned SyncDepth =
      (SYNC_STAGES < EPP_SYNC_MIN) ? EPP_SYNC_MIN : SYNC_STAGES;

  logic [2:0] strb_s;
  logic [7:0] d_s;
  logic       astb_s, dstb_s, wr_s;

  sync_vec #(
    .WIDTH  (3),
    .STAGES (SyncDepth)
  ) u_sync_strb (
    .clk (clk_ndf),
    .rst (rst),
    .d   ({epp_astb_n, epp_dstb_n, epp_wr_n}),
    .q   (strb_s)
  );

  // Bus is only consumed while a strobe is already stable low, so bit skew is harmless.
  sync_vec #(
    .WIDTH  (8),
    .STAGES (SyncDepth)
  ) u_sync_data (
    .clk (clk_ndf),
    .rst (rst),
    .d   (epp_d_in),
    .q   (d_s)
  );

  assign astb_s = strb_s[2];
  assign dstb_s = strb_s[1];
  assign wr_s   = strb_s[0];

  epp_state_e state_q, state_d;
  logic [7:0] cur_addr_q, cur_addr_d;
  logic [7:0] q_q, q_d;
  logic       wait_q, wait_d;
  logic       oe_q, oe_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       cyc_type_q, cyc_type_d;
  logic       cyc_data_q, cyc_data_d;

  // Next-state decode and output updates for the EPP handshake FSM.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    q_d        = q_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    err_cnt_d  = err_cnt_q;
    cyc_type_d = cyc_type_q;
    cyc_data_d = cyc_data_q;

    case (state_q)
      // Wait out any cycle that was in flight when reset hit.
      StSettle: begin
        if (astb_s && dstb_s) state_d = StIdle;
      end
      StIdle: begin
        if (!astb_s && !dstb_s) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (!astb_s) begin
          cyc_data_d = 1'b0;
          if (!wr_s) begin
            cyc_type_d = CYC_WRITE;
            cur_addr_d = d_s;
            state_d    = StAwr;
          end else begin
            cyc_type_d = CYC_READ;
            q_d        = cur_addr_q;
            state_d    = StArd;
          end
        end else if (!dstb_s) begin
          cyc_data_d = 1'b1;
          if (!wr_s) begin
            cyc_type_d = CYC_WRITE;
            wr_addr_d  = cur_addr_q;
            wr_data_d  = d_s;
            wr_valid_d = 1'b1;
            state_d    = StDwr;
          end else begin
            cyc_type_d = CYC_READ;
            rd_addr_d  = cur_addr_q;
            rd_valid_d = 1'b1;
            state_d    = StDrdReq;
          end
        end
      end
      StAwr, StArd: begin
        state_d = StAck;
      end
      StDwr: begin
        if (wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = StAck;
        end
      end
      StDrdReq: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = StDrdWait;
        end
      end
      StDrdWait: begin
        if (rsp_valid) begin
          q_d     = rsp_data;
          state_d = StAck;
        end
      end
      StAck: begin
        // Release on whichever strobe opened this cycle.
        if (cyc_data_q ? dstb_s : astb_s) state_d = StIdle;
      end
      default: state_d = StSettle;
    endcase

    // Pad-facing controls are decoded from the next state so the flops track it exactly.
    wait_d = (state_d == StAck);
    oe_d   = drives_bus(state_d, cyc_type_d);
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk_ndf) begin
    if (rst) begin
      state_q    <= StSettle;
      cur_addr_q <= 8'h00;
      q_q        <= 8'h00;
      wait_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= 8'h00;
      err_cnt_q  <= 8'h00;
      cyc_type_q <= CYC_WRITE;
      cyc_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      q_q        <= q_d;
      wait_q     <= wait_d;
      oe_q       <= oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      err_cnt_q  <= err_cnt_d;
      cyc_type_q <= cyc_type_d;
      cyc_data_q <= cyc_data_d;
    end
  end

  assign epp_q      = q_q;
  assign epp_q_oe   = oe_q;
  assign epp_wait_n = wait_q;
  assign cur_addr   = cur_addr_q;
  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_addr    = rd_addr_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_epp_slave.sv
// Self-checking bench for epp_slave: host-side EPP cycles against a queue of expected results.
module tb_epp_slave;

  localparam int unsigned SYNC_STAGES = 2;

  logic       clk_ndf = 1'b0;
  logic       rst;
  logic       epp_astb_n, epp_dstb_n, epp_wr_n;
  logic [7:0] epp_d_in;
  logic [7:0] epp_q;
  logic       epp_q_oe;
  logic       epp_wait_n;
  logic [7:0] cur_addr;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_addr, wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_addr;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] wr_exp_q[$];  // {addr, data} of expected write transactions
  logic [7:0]  q_exp_q[$];   // expected epp_q at read acknowledge

  epp_slave #(
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_ndf    (clk_ndf),
    .rst        (rst),
    .epp_astb_n (epp_astb_n),
    .epp_dstb_n (epp_dstb_n),
    .epp_wr_n   (epp_wr_n),
    .epp_d_in   (epp_d_in),
    .epp_q      (epp_q),
    .epp_q_oe   (epp_q_oe),
    .epp_wait_n (epp_wait_n),
    .cur_addr   (cur_addr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .err_cnt    (err_cnt)
  );

  // 20 MHz
  always #25 clk_ndf = ~clk_ndf;

  task automatic tick();
    @(posedge clk_ndf);
    #1;
  endtask

  // Waits (bounded) for epp_wait_n to reach val; also notes any downstream request seen.
  task automatic wait_for_wait(input logic val, input int max_cycles, output int cycles,
                               output bit ok, output bit saw_req);
    cycles  = 0;
    ok      = 1'b0;
    saw_req = 1'b0;
    while (cycles < max_cycles) begin
      tick();
      cycles++;
      if (wr_valid === 1'b1 || rd_valid === 1'b1) saw_req = 1'b1;
      if (epp_wait_n === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_addr_write(input logic [7:0] a);
    int c;
    bit ok, s;
    epp_d_in = a; epp_wr_n = 1'b0; epp_astb_n = 1'b0;
    wait_for_wait(1'b1, 20, c, ok, s);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL aw_setup_ack: epp_wait_n=%b required 1 within 20 cycles", epp_wait_n);
    end
    epp_astb_n = 1'b1; epp_wr_n = 1'b1;
    wait_for_wait(1'b0, 20, c, ok, s);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL aw_setup_release: epp_wait_n=%b required 0 within 20 cycles", epp_wait_n);
    end
  endtask

  task automatic do_addr_read(output logic [7:0] q, output logic oe, output bit ok);
    int c;
    bit s;
    epp_wr_n = 1'b1; epp_astb_n = 1'b0;
    wait_for_wait(1'b1, 20, c, ok, s);
    q  = epp_q;
    oe = epp_q_oe;
    epp_astb_n = 1'b1;
    wait_for_wait(1'b0, 20, c, ok, s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    epp_astb_n = 1'b1; epp_dstb_n = 1'b1; epp_wr_n = 1'b1; epp_d_in = 8'h00;
    wr_ready = 1'b0; rd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 8'h00;
    repeat (3) tick();
    checks++;
    if ({epp_wait_n, epp_q, epp_q_oe, cur_addr, wr_valid, rd_valid, wr_addr, wr_data, rd_addr,
         err_cnt} !== 52'h0) begin
      errors++;
      $display("FAIL reset_values: wait_n=%b q=%h oe=%b addr=%h wv=%b rv=%b wa=%h wd=%h ra=%h err=%h required all zero",
               epp_wait_n, epp_q, epp_q_oe, cur_addr, wr_valid, rd_valid, wr_addr, wr_data,
               rd_addr, err_cnt);
    end
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_addr_write();
    int c;
    bit ok, s1, s2;
    epp_d_in = 8'h42; epp_wr_n = 1'b0; epp_astb_n = 1'b0;
    wait_for_wait(1'b1, 20, c, ok, s1);
    checks++;
    if (!ok || c != int'(SYNC_STAGES) + 2) begin
      errors++;
      $display("FAIL aw_ack_latency: cycles=%0d ok=%b required %0d", c, ok, SYNC_STAGES + 2);
    end
    checks++;
    if (cur_addr !== 8'h42) begin
      errors++;
      $display("FAIL aw_cur_addr: got %h required 42", cur_addr);
    end
    checks++;
    if (epp_q_oe !== 1'b0) begin
      errors++;
      $display("FAIL aw_oe: got %b required 0", epp_q_oe);
    end
    epp_astb_n = 1'b1; epp_wr_n = 1'b1;
    wait_for_wait(1'b0, 20, c, ok, s2);
    checks++;
    if (!ok || c != int'(SYNC_STAGES) + 1) begin
      errors++;
      $display("FAIL aw_release_latency: cycles=%0d ok=%b required %0d", c, ok, SYNC_STAGES + 1);
    end
    checks++;
    if (s1 || s2) begin
      errors++;
      $display("FAIL aw_no_request: saw wr/rd valid=%b required 0", s1 | s2);
    end
  endtask

  task automatic test_data_write();
    int c;
    bit ok, s, bad;
    logic [15:0] exp;
    do_addr_write(8'h43);
    wr_ready = 1'b0;
    epp_d_in = 8'hFF; epp_wr_n = 1'b0; epp_dstb_n = 1'b0;
    wr_exp_q.push_back({8'h43, 8'hFF});
    c = 0;
    while (wr_valid !== 1'b1 && c < 20) begin tick(); c++; end
    checks++;
    if (wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL dw_valid: wr_valid=%b required 1 within 20 cycles", wr_valid);
    end
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (wr_valid !== 1'b1 || wr_addr !== 8'h43 || wr_data !== 8'hFF || epp_wait_n !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL dw_backpressure_hold: wv=%b wa=%h wd=%h wait_n=%b required stable 1/43/FF/0",
               wr_valid, wr_addr, wr_data, epp_wait_n);
    end
    wr_ready = 1'b1;
    exp = wr_exp_q.pop_front();
    checks++;
    if ({wr_addr, wr_data} !== exp) begin
      errors++;
      $display("FAIL dw_payload: got %h required %h", {wr_addr, wr_data}, exp);
    end
    tick();
    wr_ready = 1'b0;
    checks++;
    if (wr_valid !== 1'b0 || epp_wait_n !== 1'b1) begin
      errors++;
      $display("FAIL dw_handshake_ack: wv=%b wait_n=%b required 0/1", wr_valid, epp_wait_n);
    end
    epp_dstb_n = 1'b1; epp_wr_n = 1'b1;
    wait_for_wait(1'b0, 20, c, ok, s);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dw_release: epp_wait_n=%b required 0 within 20 cycles", epp_wait_n);
    end
  endtask

  task automatic test_data_read();
    int c;
    bit ok, s, bad;
    logic [7:0] exp;
    do_addr_write(8'h44);
    epp_wr_n = 1'b1; epp_dstb_n = 1'b0;
    c = 0;
    while (rd_valid !== 1'b1 && c < 20) begin tick(); c++; end
    checks++;
    if (rd_valid !== 1'b1 || rd_addr !== 8'h44 || epp_q_oe !== 1'b1) begin
      errors++;
      $display("FAIL dr_request: rv=%b ra=%h oe=%b required 1/44/1", rd_valid, rd_addr, epp_q_oe);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL dr_handshake: rv=%b required 0", rd_valid);
    end
    bad = 1'b0;
    repeat (9) begin
      tick();
      if (epp_wait_n !== 1'b0 || epp_q_oe !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL dr_wait_hold: wait_n=%b oe=%b required 0/1", epp_wait_n, epp_q_oe);
    end
    rsp_valid = 1'b1; rsp_data = 8'hEC;
    q_exp_q.push_back(8'hEC);
    tick();
    rsp_valid = 1'b0; rsp_data = 8'h00;
    exp = q_exp_q.pop_front();
    checks++;
    if (epp_q !== exp || epp_q_oe !== 1'b1 || epp_wait_n !== 1'b1) begin
      errors++;
      $display("FAIL dr_response: q=%h oe=%b wait_n=%b required %h/1/1", epp_q, epp_q_oe,
               epp_wait_n, exp);
    end
    epp_dstb_n = 1'b1;
    wait_for_wait(1'b0, 20, c, ok, s);
    checks++;
    if (!ok || epp_q_oe !== 1'b0) begin
      errors++;
      $display("FAIL dr_oe_release: ok=%b oe=%b required 1/0", ok, epp_q_oe);
    end
  endtask

  task automatic test_addr_read();
    logic [7:0] q, exp;
    logic oe;
    bit ok;
    q_exp_q.push_back(8'h44);
    do_addr_read(q, oe, ok);
    exp = q_exp_q.pop_front();
    checks++;
    if (!ok || q !== exp || oe !== 1'b1) begin
      errors++;
      $display("FAIL ar_value: ok=%b q=%h oe=%b required 1/%h/1", ok, q, oe, exp);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    bit ok, s;
    logic [7:0] vals [2];
    logic [15:0] exp;
    vals[0] = 8'h11; vals[1] = 8'h22;
    wr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      epp_d_in = vals[i]; epp_wr_n = 1'b0; epp_dstb_n = 1'b0;
      wr_exp_q.push_back({8'h44, vals[i]});
      c = 0;
      while (wr_valid !== 1'b1 && c < 20) begin tick(); c++; end
      exp = wr_exp_q.pop_front();
      checks++;
      if (wr_valid !== 1'b1 || {wr_addr, wr_data} !== exp) begin
        errors++;
        $display("FAIL b2b_write%0d: wv=%b got %h required %h", i, wr_valid, {wr_addr, wr_data},
                 exp);
      end
      wait_for_wait(1'b1, 20, c, ok, s);
      epp_dstb_n = 1'b1; epp_wr_n = 1'b1;
      wait_for_wait(1'b0, 20, c, ok, s);
    end
    wr_ready = 1'b0;
  endtask

  task automatic test_protocol_error();
    logic [7:0] base;
    base = err_cnt;
    epp_wr_n = 1'b1;
    epp_astb_n = 1'b0; epp_dstb_n = 1'b0;
    tick();
    epp_astb_n = 1'b1; epp_dstb_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (err_cnt !== base + 8'd1) begin
      errors++;
      $display("FAIL perr_single: err_cnt=%h required %h", err_cnt, base + 8'd1);
    end
    checks++;
    if (epp_wait_n !== 1'b0 || wr_valid !== 1'b0 || rd_valid !== 1'b0 || epp_q_oe !== 1'b0) begin
      errors++;
      $display("FAIL perr_idle: wait_n=%b wv=%b rv=%b oe=%b required all 0", epp_wait_n,
               wr_valid, rd_valid, epp_q_oe);
    end
    for (int n = 0; n < 299; n++) begin
      epp_astb_n = 1'b0; epp_dstb_n = 1'b0;
      tick();
      epp_astb_n = 1'b1; epp_dstb_n = 1'b1;
      tick();
      if (n == 252) begin
        repeat (4) tick();
        checks++;
        if (err_cnt !== 8'hFE) begin
          errors++;
          $display("FAIL perr_count_254: err_cnt=%h required fe", err_cnt);
        end
      end
    end
    repeat (4) tick();
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL perr_saturate: err_cnt=%h required ff", err_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    int c;
    bit ok, bad;
    logic [7:0] q, exp;
    logic oe;
    do_addr_write(8'h55);
    epp_wr_n = 1'b1; epp_dstb_n = 1'b0;
    c = 0;
    while (rd_valid !== 1'b1 && c < 20) begin tick(); c++; end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({epp_wait_n, epp_q, epp_q_oe, cur_addr, wr_valid, rd_valid, wr_addr, wr_data, rd_addr,
         err_cnt} !== 52'h0) begin
      errors++;
      $display("FAIL rst_mid_values: wait_n=%b q=%h oe=%b addr=%h wv=%b rv=%b ra=%h err=%h required all zero",
               epp_wait_n, epp_q, epp_q_oe, cur_addr, wr_valid, rd_valid, rd_addr, err_cnt);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n == 4) begin rsp_valid = 1'b1; rsp_data = 8'hAB; end
      tick();
      rsp_valid = 1'b0; rsp_data = 8'h00;
      if (rd_valid !== 1'b0 || wr_valid !== 1'b0 || epp_wait_n !== 1'b0 || epp_q !== 8'h00 ||
          epp_q_oe !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_settle_hold: rv=%b wait_n=%b q=%h oe=%b required 0/0/00/0", rd_valid,
               epp_wait_n, epp_q, epp_q_oe);
    end
    epp_dstb_n = 1'b1;
    repeat (5) tick();
    q_exp_q.push_back(8'h00);
    do_addr_read(q, oe, ok);
    exp = q_exp_q.pop_front();
    checks++;
    if (!ok || q !== exp || oe !== 1'b1) begin
      errors++;
      $display("FAIL rst_addr_read_zero: ok=%b q=%h oe=%b required 1/%h/1", ok, q, oe, exp);
    end
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_data_write();
    test_data_read();
    test_addr_read();
    test_back_to_back();
    test_protocol_error();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
